// File: rtl/fetch_pkg.sv
// Shared state encoding and sizing constants for the instruction fetch path.
package fetch_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_HALT  = 2'd2,
        ST_FAULT = 2'd3
    } fetch_state_t;

    localparam int INSTR_BYTES     = 4;
    localparam int DEF_ADDR_WIDTH  = 64;
    localparam int DEF_INSTR_WIDTH = 32;
    localparam int ENTRY_WIDTH     = DEF_ADDR_WIDTH + DEF_INSTR_WIDTH;

    function automatic logic is_aligned(input logic [1:0] lsb);
        return lsb == 2'b00;
    endfunction

endpackage

// File: rtl/fetch_controller_if.sv
// Fetch controller bus: control pulses, memory port and the decode handshake.
interface fetch_controller_if #(
    parameter int ADDR_WIDTH  = 64,
    parameter int INSTR_WIDTH = 32
);
    logic                   start;
    logic                   halt_req;
    logic                   redirect;
    logic [ADDR_WIDTH-1:0]  redirect_pc;
    logic [ADDR_WIDTH-1:0]  instr_addr;
    logic [INSTR_WIDTH-1:0] instr_data;
    logic                   out_valid;
    logic                   out_ready;
    logic [INSTR_WIDTH-1:0] out_instr;
    logic [ADDR_WIDTH-1:0]  out_pc;
    logic                   running;
    logic                   fault;
    logic [31:0]            fetch_count;

    modport master (
        input  start, halt_req, redirect, redirect_pc, instr_data, out_ready,
        output instr_addr, out_valid, out_instr, out_pc, running, fault, fetch_count
    );

    modport slave (
        output start, halt_req, redirect, redirect_pc, instr_data, out_ready,
        input  instr_addr, out_valid, out_instr, out_pc, running, fault, fetch_count
    );
endinterface

// File: rtl/fetch_queue.sv
// In-order fetch queue; head is read straight from register storage.
// Latency 1 cycle push-to-head; flush empties the queue on the next edge.
module fetch_queue
    import fetch_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int WIDTH = ENTRY_WIDTH
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   i_push,
    input  logic                   i_pop,
    input  logic                   i_flush,
    input  logic [WIDTH-1:0]       i_push_dat,
    output logic [$clog2(DEPTH):0] o_count,
    output logic [WIDTH-1:0]       o_head_dat
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PW-1:0]    r_rd;
    logic [PW-1:0]    r_wr;
    logic [CW-1:0]    r_count;

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
            r_rd    <= '0;
            r_wr    <= '0;
            r_count <= '0;
        end else if (i_flush) begin
            r_rd    <= '0;
            r_wr    <= '0;
            r_count <= '0;
        end else begin
            if (i_push) begin
                r_mem[r_wr] <= i_push_dat;
                r_wr        <= r_wr + PW'(1);
            end
            if (i_pop) r_rd <= r_rd + PW'(1);
            r_count <= r_count + CW'(i_push) - CW'(i_pop);
        end
    end

    assign o_count    = r_count;
    assign o_head_dat = r_mem[r_rd];
endmodule

// File: rtl/fetch_controller.sv
// Owns the PC, fetches one instruction per cycle into the queue while running.
// Latency: fetched word reaches the queue head one cycle after its address is driven.
module fetch_controller
    import fetch_pkg::*;
#(
    parameter logic [63:0] RESET_PC    = 64'd0,
    parameter int          QUEUE_DEPTH = 2,
    parameter int          ADDR_WIDTH  = 64,
    parameter int          INSTR_WIDTH = 32
) (
    input  logic          clk,
    input  logic          reset,
    fetch_controller_if.master fc
);
    localparam int CW = $clog2(QUEUE_DEPTH) + 1;
    localparam int EW = INSTR_WIDTH + ADDR_WIDTH;

    fetch_state_t            r_state;
    fetch_state_t            w_state_nxt;
    logic [ADDR_WIDTH-1:0]   r_pc;
    logic [ADDR_WIDTH-1:0]   w_pc_nxt;
    logic                    r_fault;
    logic [31:0]             r_fetch_count;
    logic [CW-1:0]           w_count;
    logic [EW-1:0]           w_head;
    logic                    w_deq;
    logic                    w_enq;
    logic                    w_flush;
    logic                    w_bad_target;

    assign w_deq        = fc.out_valid && fc.out_ready;
    assign w_flush      = fc.redirect && (r_state != ST_FAULT);
    assign w_bad_target = w_flush && !is_aligned(fc.redirect_pc[1:0]);

    always_comb begin
        w_state_nxt = r_state;
        w_pc_nxt    = r_pc;
        w_enq       = 1'b0;
        if (w_flush) begin
            // Redirect dominates: halt/start in the same cycle are dropped.
            if (w_bad_target) w_state_nxt = ST_FAULT;
            else              w_pc_nxt    = fc.redirect_pc;
        end else if (fc.halt_req && r_state == ST_RUN) begin
            w_state_nxt = ST_HALT;
        end else begin
            if (fc.start && (r_state == ST_IDLE || r_state == ST_HALT))
                w_state_nxt = ST_RUN;
            if (r_state == ST_RUN &&
                (w_count != CW'(QUEUE_DEPTH) || w_deq)) begin
                w_enq    = 1'b1;
                w_pc_nxt = r_pc + ADDR_WIDTH'(INSTR_BYTES);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) r_state <= ST_IDLE;
        else       r_state <= w_state_nxt;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_pc          <= RESET_PC[ADDR_WIDTH-1:0];
            r_fault       <= 1'b0;
            r_fetch_count <= '0;
        end else begin
            r_pc          <= w_pc_nxt;
            r_fault       <= r_fault | w_bad_target;
            r_fetch_count <= r_fetch_count + 32'(w_enq);
        end
    end

    fetch_queue #(
        .DEPTH (QUEUE_DEPTH),
        .WIDTH (EW)
    ) u_queue (
        .clk        (clk),
        .reset      (reset),
        .i_push     (w_enq),
        .i_pop      (w_deq),
        .i_flush    (w_flush),
        .i_push_dat ({fc.instr_data, r_pc}),
        .o_count    (w_count),
        .o_head_dat (w_head)
    );

    assign fc.instr_addr  = r_pc;
    assign fc.out_valid   = (w_count != '0);
    assign fc.out_instr   = w_head[ADDR_WIDTH +: INSTR_WIDTH];
    assign fc.out_pc      = w_head[ADDR_WIDTH-1:0];
    assign fc.running     = (r_state == ST_RUN);
    assign fc.fault       = r_fault;
    assign fc.fetch_count = r_fetch_count;
endmodule

// File: tb/tb_fetch_controller.sv
// Directed bench for fetch_controller against a combinational instruction memory.
module tb_fetch_controller;
    logic clk;
    logic reset;
    int   n_tests;
    int   n_fail;

    fetch_controller_if #(.ADDR_WIDTH(64), .INSTR_WIDTH(32)) bus ();

    fetch_controller #(
        .RESET_PC    (64'd0),
        .QUEUE_DEPTH (2),
        .ADDR_WIDTH  (64),
        .INSTR_WIDTH (32)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .fc    (bus.master)
    );

    function automatic logic [31:0] mem(input logic [63:0] a);
        return a[31:0] ^ 32'h1357_9BDF;
    endfunction

    assign bus.instr_data = mem(bus.instr_addr);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        reset = 1'b1;
        bus.start = 1'b0;
        bus.halt_req = 1'b0;
        bus.redirect = 1'b0;
        bus.redirect_pc = '0;
        bus.out_ready = 1'b0;
        step();
        step();
        chk("rst_valid", bus.out_valid, 0);
        chk("rst_addr", bus.instr_addr, 0);
        chk("rst_running", bus.running, 0);
        chk("rst_fault", bus.fault, 0);
        chk("rst_count", bus.fetch_count, 0);
        chk("rst_instr", bus.out_instr, 0);
        chk("rst_pc", bus.out_pc, 0);

        // Streaming with decode always ready
        reset = 1'b0;
        bus.start = 1'b1;
        bus.out_ready = 1'b1;
        step();
        bus.start = 1'b0;
        chk("start_running", bus.running, 1);
        chk("start_no_fetch", bus.out_valid, 0);
        for (int i = 0; i < 10; i++) begin
            step();
            chk("stream_pc", bus.out_pc, 64'(4 * i));
            chk("stream_instr", bus.out_instr, mem(64'(4 * i)));
            chk("stream_addr", bus.instr_addr, 64'(4 * (i + 1)));
        end
        chk("stream_count", bus.fetch_count, 10);

        // Backpressure: queue fills to two and pc stalls
        reset = 1'b1;
        bus.out_ready = 1'b0;
        step();
        reset = 1'b0;
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        for (int i = 0; i < 5; i++) step();
        chk("bp_addr", bus.instr_addr, 8);
        chk("bp_count", bus.fetch_count, 2);
        chk("bp_valid", bus.out_valid, 1);
        chk("bp_head", bus.out_pc, 0);
        bus.out_ready = 1'b1;
        step();
        chk("bp_drain1", bus.out_pc, 4);
        chk("bp_addr1", bus.instr_addr, 12);
        step();
        chk("bp_drain2", bus.out_pc, 8);
        chk("bp_count2", bus.fetch_count, 4);

        // Redirect to 0x28 flushes two queued entries
        reset = 1'b1;
        bus.out_ready = 1'b0;
        step();
        reset = 1'b0;
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        step();
        step();
        chk("rd_pre_addr", bus.instr_addr, 8);
        bus.redirect = 1'b1;
        bus.redirect_pc = 64'h28;
        step();
        bus.redirect = 1'b0;
        bus.out_ready = 1'b1;
        chk("rd_flush", bus.out_valid, 0);
        chk("rd_addr", bus.instr_addr, 64'h28);
        chk("rd_running", bus.running, 1);
        step();
        chk("rd_head_pc", bus.out_pc, 64'h28);
        chk("rd_head_instr", bus.out_instr, mem(64'h28));
        chk("rd_addr2", bus.instr_addr, 64'h2C);

        // Misaligned redirect faults; start is ignored until reset
        bus.redirect = 1'b1;
        bus.redirect_pc = 64'h2A;
        step();
        bus.redirect = 1'b0;
        chk("flt_fault", bus.fault, 1);
        chk("flt_running", bus.running, 0);
        chk("flt_addr", bus.instr_addr, 64'h2C);
        chk("flt_valid", bus.out_valid, 0);
        bus.start = 1'b1;
        step();
        step();
        bus.start = 1'b0;
        chk("flt_start_ign", bus.running, 0);
        chk("flt_no_fetch", bus.fetch_count, 3);
        chk("flt_addr_hold", bus.instr_addr, 64'h2C);
        chk("flt_sticky", bus.fault, 1);
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("flt_clear", bus.fault, 0);
        chk("flt_rst_addr", bus.instr_addr, 0);

        // Halt at pc=16 with entries 8 and 12 queued, then resume
        bus.start = 1'b1;
        bus.out_ready = 1'b1;
        step();
        bus.start = 1'b0;
        step();
        step();
        step();
        bus.out_ready = 1'b0;
        step();
        chk("hlt_pre_addr", bus.instr_addr, 16);
        chk("hlt_pre_head", bus.out_pc, 8);
        bus.halt_req = 1'b1;
        bus.out_ready = 1'b1;
        step();
        bus.halt_req = 1'b0;
        chk("hlt_running", bus.running, 0);
        chk("hlt_drain1", bus.out_pc, 12);
        chk("hlt_addr", bus.instr_addr, 16);
        step();
        chk("hlt_empty", bus.out_valid, 0);
        step();
        chk("hlt_addr_hold", bus.instr_addr, 16);
        chk("hlt_count", bus.fetch_count, 4);
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        chk("hlt_resume", bus.running, 1);
        step();
        chk("hlt_res_pc", bus.out_pc, 16);
        chk("hlt_res_addr", bus.instr_addr, 20);

        // Redirect near the top of the address space and wrap
        bus.redirect = 1'b1;
        bus.redirect_pc = 64'hFFFF_FFFF_FFFF_FFFC;
        step();
        bus.redirect = 1'b0;
        chk("wrap_flush", bus.out_valid, 0);
        chk("wrap_addr", bus.instr_addr, 64'hFFFF_FFFF_FFFF_FFFC);
        step();
        chk("wrap_pc_top", bus.out_pc, 64'hFFFF_FFFF_FFFF_FFFC);
        chk("wrap_instr", bus.out_instr, mem(64'hFFFF_FFFF_FFFF_FFFC));
        chk("wrap_addr0", bus.instr_addr, 0);
        step();
        chk("wrap_pc0", bus.out_pc, 0);
        chk("wrap_addr4", bus.instr_addr, 4);
        reset = 1'b1;
        step();
        chk("mid_rst_valid", bus.out_valid, 0);
        chk("mid_rst_addr", bus.instr_addr, 0);
        chk("mid_rst_count", bus.fetch_count, 0);
        chk("mid_rst_running", bus.running, 0);
        reset = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
